// File: rtl/mio_pkg.sv
// Shared encodings for the CPU/peripheral memory arbiter (mio_arbiter).
// State encoding, requester/owner encoding and the default memory latency.
package mio_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } mio_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DEV = 1'b1;

  localparam int MEM_LAT_DEFAULT = 1;
  // Latency counter width: covers the legal MEM_LAT range 1..7.
  localparam int LAT_W = 3;

endpackage

// File: rtl/mio_rr_pick.sv
// Two-input requester picker for mio_arbiter: round-robin on ties by default,
// fixed CPU priority when MIO_CPU_PRIO_EN is defined.
module mio_rr_pick
  import mio_pkg::*;
(
  input  logic cpu_req,
  input  logic dev_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

`ifdef MIO_CPU_PRIO_EN
  // last_grant is still tracked by the top but plays no part in the tie-break.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid = cpu_req | dev_req;
    grant = OWN_CPU;
    if (cpu_req && dev_req) begin
`ifdef MIO_CPU_PRIO_EN
      grant = OWN_CPU;
`else
      grant = ~last_grant;
`endif
    end else if (dev_req) begin
      grant = OWN_DEV;
    end
  end

endmodule

// File: rtl/mio_arbiter.sv
// Shares one single-port synchronous memory between the CPU MIO port and a
// read-only peripheral. Optional fixed CPU priority via MIO_CPU_PRIO_EN.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              MIO_ready,
  input  logic              dev_req,
  input  logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);

  mio_state_t        state;
  logic              owner;
  logic              last_grant;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] rdata_q;

  logic pick_valid;
  logic pick_grant;

  mio_rr_pick u_pick (
    .cpu_req    (cpu_req),
    .dev_req    (dev_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // Both requesters read from the same captured register; the pulses say whose it is.
  assign cpu_rdata = rdata_q;
  assign dev_rdata = rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_DEV;
      lat_cnt    <= '0;
      rdata_q    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      MIO_ready  <= 1'b0;
      dev_ack    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      MIO_ready <= 1'b0;
      dev_ack   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner      <= pick_grant;
            last_grant <= pick_grant;
            lat_cnt    <= LAT_LOAD;
            mem_en     <= 1'b1;
            if (pick_grant == OWN_CPU) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= cpu_we;
            end else begin
              mem_addr  <= dev_addr;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
            end
            state <= S_ACCESS;
            busy  <= 1'b1;
          end
        end

        S_ACCESS: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            rdata_q   <= mem_rdata;
            MIO_ready <= (owner == OWN_CPU);
            dev_ack   <= (owner == OWN_DEV);
            state     <= S_RESP;
          end
        end

        // Requests are deliberately not sampled here, so a still-held
        // request is never re-granted off its own completion cycle.
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed self-checking bench for mio_arbiter: MEM_LAT=1 main instance plus a
// MEM_LAT=3 instance; expected read data and grant order kept in queues.
module tb_mio_arbiter;
  import mio_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (MEM_LAT = 1)
  logic          cpu_req, cpu_we, dev_req;
  logic [AW-1:0] cpu_addr, dev_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dev_rdata, mem_rdata;
  logic          MIO_ready, dev_ack, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  mio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
    .dev_req(dev_req), .dev_addr(dev_addr), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second instance (MEM_LAT = 3)
  logic          cpu_req3, cpu_we3, dev_req3;
  logic [AW-1:0] cpu_addr3, dev_addr3;
  logic [DW-1:0] cpu_wdata3, cpu_rdata3, dev_rdata3, mem_rdata3;
  logic          MIO_ready3, dev_ack3, mem_en3, mem_we3, busy3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_wdata3;

  mio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .MIO_ready(MIO_ready3),
    .dev_req(dev_req3), .dev_addr(dev_addr3), .dev_rdata(dev_rdata3), .dev_ack(dev_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  logic          own_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_mem_en"},    {31'd0, mem_en},    32'd0);
    check({pfx, "_mem_we"},    {31'd0, mem_we},    32'd0);
    check({pfx, "_mem_addr"},  mem_addr,           32'd0);
    check({pfx, "_mem_wdata"}, mem_wdata,          32'd0);
    check({pfx, "_mio_ready"}, {31'd0, MIO_ready}, 32'd0);
    check({pfx, "_dev_ack"},   {31'd0, dev_ack},   32'd0);
    check({pfx, "_cpu_rdata"}, cpu_rdata,          32'd0);
    check({pfx, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  // Per-run observations of the main instance
  int            m_en_cyc, m_en_cnt, m_pulse_cyc, m_cpu_p, m_dev_p;
  logic          m_en_we, m_busy_after;
  logic [AW-1:0] m_en_addr;
  logic [DW-1:0] m_en_wdata, m_rdata;

  // Observe ncyc cycles after the request was driven; requesters drop on their
  // completion pulse, and both drop at drop_cyc when it is non-zero.
  task automatic mon(input int ncyc, input int drop_cyc);
    m_en_cyc = -1; m_en_cnt = 0; m_pulse_cyc = -1; m_cpu_p = 0; m_dev_p = 0;
    m_en_we = 1'bx; m_busy_after = 1'bx; m_en_addr = 'x; m_en_wdata = 'x; m_rdata = 'x;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (m_en_cyc < 0) begin
          m_en_cyc = k; m_en_we = mem_we; m_en_addr = mem_addr; m_en_wdata = mem_wdata;
        end
        m_en_cnt++;
      end
      if (m_pulse_cyc > 0 && k == m_pulse_cyc + 1) m_busy_after = busy;
      if (MIO_ready) begin
        m_cpu_p++;
        if (m_pulse_cyc < 0) begin m_pulse_cyc = k; m_rdata = cpu_rdata; end
        cpu_req = 1'b0;
      end
      if (dev_ack) begin
        m_dev_p++;
        if (m_pulse_cyc < 0) begin m_pulse_cyc = k; m_rdata = dev_rdata; end
        dev_req = 1'b0;
      end
      if (k == drop_cyc) begin cpu_req = 1'b0; dev_req = 1'b0; end
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   en_cyc3, en_cnt3, pulse_cyc3, cpu_p3, busy_cnt3;
    logic [AW-1:0] en_addr3;
    logic          en_we3;
    logic [DW-1:0] rdata3;
    int   prev, npulse;
    logic got;
    logic [AW-1:0] last_en_addr;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; dev_req = 0; dev_addr = '0; mem_rdata = '0;
    cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0; dev_req3 = 0; dev_addr3 = '0; mem_rdata3 = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_busy3", {31'd0, busy3}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // CPU read, MEM_LAT=1
    mem_rdata = 32'h8C01_0014;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
    exp_q.push_back(32'h8C01_0014);
    mon(5, 0);
    check("rd_en_cyc", m_en_cyc, 1);
    check("rd_en_cnt", m_en_cnt, 1);
    check("rd_en_we", {31'd0, m_en_we}, 0);
    check("rd_en_addr", m_en_addr, 32'h14);
    check("rd_pulse_cyc", m_pulse_cyc, 2);
    check("rd_cpu_pulses", m_cpu_p, 1);
    check("rd_dev_pulses", m_dev_p, 0);
    check("rd_rdata", m_rdata, exp_q.pop_front());
    check("rd_busy_after", {31'd0, m_busy_after}, 0);

    // CPU write
    mem_rdata = 32'h5555_AAAA;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
    mon(6, 0);
    cpu_we = 0;
    check("wr_en_cyc", m_en_cyc, 1);
    check("wr_en_cnt", m_en_cnt, 1);
    check("wr_en_we", {31'd0, m_en_we}, 1);
    check("wr_en_addr", m_en_addr, 32'h20);
    check("wr_en_wdata", m_en_wdata, 32'hDEAD_BEEF);
    check("wr_pulse_cyc", m_pulse_cyc, 2);
    check("wr_cpu_pulses", m_cpu_p, 1);
    check("wr_dev_pulses", m_dev_p, 0);

    // MEM_LAT=3 dev read: memory data changes each ACCESS cycle, the last one counts
    dev_req3 = 1; dev_addr3 = 32'h100;
    exp_q.push_back(32'h3333_3333);
    en_cyc3 = -1; en_cnt3 = 0; pulse_cyc3 = -1; cpu_p3 = 0; busy_cnt3 = 0;
    en_addr3 = 'x; en_we3 = 1'bx; rdata3 = 'x;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (mem_en3) begin
        if (en_cyc3 < 0) begin en_cyc3 = k; en_addr3 = mem_addr3; en_we3 = mem_we3; end
        en_cnt3++;
      end
      if (dev_ack3) begin
        if (pulse_cyc3 < 0) begin pulse_cyc3 = k; rdata3 = dev_rdata3; end
        dev_req3 = 0;
      end
      if (MIO_ready3) cpu_p3++;
      if (busy3) busy_cnt3++;
      mem_rdata3 = (k <= 3) ? 32'(k) * 32'h1111_1111 : 32'hFFFF_FFFF;
    end
    check("lat3_en_cyc", en_cyc3, 1);
    check("lat3_en_cnt", en_cnt3, 1);
    check("lat3_en_addr", en_addr3, 32'h100);
    check("lat3_en_we", {31'd0, en_we3}, 0);
    check("lat3_pulse_cyc", pulse_cyc3, 4);
    check("lat3_rdata", rdata3, exp_q.pop_front());
    check("lat3_cpu_pulses", cpu_p3, 0);
    check("lat3_busy_cycles", busy_cnt3, 4);

    // Reset during ACCESS of a CPU read
    mem_rdata = 32'h1234_5678;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    @(negedge clk);
    check("rst_pre_mem_en", {31'd0, mem_en}, 1);
    reset = 1'b1;
    #1;
    check_zero_outputs("rst_async");
    @(negedge clk);
    check("rst_no_ready", {31'd0, MIO_ready}, 0);
    reset = 1'b0;
    exp_q.push_back(32'h1234_5678);
    mon(5, 0);
    check("rst_regrant_en_cyc", m_en_cyc, 1);
    check("rst_regrant_addr", m_en_addr, 32'h44);
    check("rst_regrant_pulse", m_pulse_cyc, 2);
    check("rst_regrant_pulses", m_cpu_p, 1);
    check("rst_regrant_rdata", m_rdata, exp_q.pop_front());

    // cpu_req dropped one cycle after the grant edge
    mem_rdata = 32'h0BAD_F00D;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    exp_q.push_back(32'h0BAD_F00D);
    mon(6, 1);
    check("drop_pulse_cyc", m_pulse_cyc, 2);
    check("drop_cpu_pulses", m_cpu_p, 1);
    check("drop_en_cnt", m_en_cnt, 1);
    check("drop_rdata", m_rdata, exp_q.pop_front());
    check("drop_busy_after", {31'd0, m_busy_after}, 0);

    // Both requesters saturating, starting from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifdef MIO_CPU_PRIO_EN
    own_q.push_back(OWN_CPU); own_q.push_back(OWN_CPU);
    own_q.push_back(OWN_CPU); own_q.push_back(OWN_CPU);
`else
    own_q.push_back(OWN_CPU); own_q.push_back(OWN_DEV);
    own_q.push_back(OWN_CPU); own_q.push_back(OWN_DEV);
`endif
    mem_rdata = 32'hCAFE_0000;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dev_req = 1; dev_addr = 32'h80;
    prev = -1; npulse = 0; last_en_addr = '0;
    for (int k = 1; k <= 40 && npulse < 4; k++) begin
      @(negedge clk);
      if (mem_en) last_en_addr = mem_addr;
      if (MIO_ready || dev_ack) begin
        got = dev_ack ? OWN_DEV : OWN_CPU;
        check("arb_onehot", {31'd0, MIO_ready & dev_ack}, 0);
        check("arb_owner", {31'd0, got}, {31'd0, own_q.pop_front()});
        check("arb_addr", last_en_addr, (got == OWN_CPU) ? 32'h40 : 32'h80);
        if (prev > 0) check("arb_period", k - prev, 3);
        prev = k;
        npulse++;
      end
    end
    cpu_req = 0; dev_req = 0;
    check("arb_count", npulse, 4);
    check("arb_q_empty", own_q.size(), 0);
    repeat (3) @(negedge clk);
    check("arb_idle_busy", {31'd0, busy}, 0);
    check("arb_idle_mem_en", {31'd0, mem_en}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
